llc_rst_flush_seq: RTL
======================

# llc_rst_flush_seq

Sequencer that walks every LLC set, one set per handshake, during cache reset and flush. It drives the per-set operation request into the LLC pipeline and tracks operations still in flight. It owns the `rst_stall` / `flush_stall` condition that holds off normal requests. It sits between the LLC top-level control (start commands) and the lookup/update pipeline (issue and acknowledge).

## Interface
Parameters:
- `SET_BITS`, 8: set index width; the sweep covers `2**SET_BITS` sets.
- `MAX_OUT`, 4: maximum number of issued but unacknowledged set operations (1..15).

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `rst_state` in 1: synchronous restart of the reset sweep, starting from set 0.
- `start_flush` in 1: one-cycle flush request.
- `op_ready` in 1: the pipeline accepts the operation offered this cycle.
- `op_ack` in 1: one in-flight operation has completed in the update stage.
- `op_valid` out 1: an operation is offered.
- `op_set` out SET_BITS: set index of the offered operation.
- `op_is_flush` out 1: 1 for a flush operation, 0 for a reset operation.
- `rst_stall` out 1: reset sweep in progress.
- `flush_stall` out 1: flush sweep in progress.
- `sweep_done` out 1: one-cycle pulse when a sweep completes.
- `outstanding` out clog2(MAX_OUT+1): current in-flight count.

## Operation
States and transitions:
- INIT → RST_SWEEP after one cycle.
- RST_SWEEP → RST_DRAIN when the last set is accepted.
- RST_DRAIN → IDLE when `outstanding` is 0. `sweep_done` pulses on this transition.
- IDLE → FL_SWEEP on `start_flush`, or on a pending flush.
- FL_SWEEP → FL_DRAIN when the last set is accepted.
- FL_DRAIN → IDLE when `outstanding` is 0. `sweep_done` pulses on this transition.

Outputs:
- `op_valid` = (state is RST_SWEEP or FL_SWEEP) and `outstanding` < MAX_OUT.
- `op_is_flush` = 1 exactly in FL_SWEEP.
- `op_set` = internal set counter.
- Set counter increments on `op_valid && op_ready`, wraps from 2**SET_BITS−1 to 0, and is cleared on entry to any sweep.
- `rst_stall` = 1 in INIT, RST_SWEEP and RST_DRAIN.
- `flush_stall` = 1 in FL_SWEEP and FL_DRAIN.

Outstanding counter:
- +1 on an accepted operation, −1 on `op_ack`.
- Both in the same cycle: unchanged.
- `op_ack` while the count is 0: ignored, no underflow.

Boundary conditions:
- `start_flush` during INIT, RST_SWEEP or RST_DRAIN: latched into a pending flag, which is cleared on entry to FL_SWEEP.
- `start_flush` during FL_SWEEP or FL_DRAIN: ignored.
- `rst_state` in any state:
  - Next state is RST_SWEEP.
  - Set counter and pending flag are cleared.
  - `outstanding` is not cleared; acknowledgements from a prior sweep still drain it.
  - `rst_state` takes priority over a same-cycle handshake and over `start_flush`.
- MAX_OUT = 1: at most one operation in flight; issue throughput is one per acknowledgement.

## Timing
- Reset values:
  - State INIT, set counter 0, `outstanding` 0, pending flag 0.
  - `op_valid` 0, `op_set` 0, `op_is_flush` 0.
  - `rst_stall` 1, `flush_stall` 0, `sweep_done` 0.
- `op_valid` is first asserted 1 cycle after reset release, with `op_set` = 0.
- With `op_ready` held at 1 and acks fast enough, one set is issued per cycle. The last set is accepted at cycle 2**SET_BITS.
- All outputs are combinational functions of registers only. No path exists from `op_ready` or `op_ack` to any output within the same cycle.
- `op_valid` may fall without a handshake only when MAX_OUT is reached or on `rst_state`; `op_set` holds until accepted.
- `sweep_done` is asserted in the first cycle of IDLE.
- A flush starts the cycle after `start_flush` is seen in IDLE. From the end of a reset sweep, a pending flush starts on the cycle after `sweep_done`.

## Configuration
- `LLC_FLUSH_SEQ_EN` defined: flush states, pending flag and `start_flush` handling are present as described.
- `LLC_FLUSH_SEQ_EN` undefined:
  - `start_flush` is ignored; FL_SWEEP and FL_DRAIN are unreachable and omitted.
  - `flush_stall` and `op_is_flush` are tied to 0.
  - The reset sweep is unchanged.

## Test plan
- Reset release with SET_BITS=3, `op_ready`=1, `op_ack` echoing each issue one cycle later → `op_set` 0..7 on cycles 1..8, `sweep_done` at cycle 10, `rst_stall` falls with it.
- MAX_OUT=2, `op_ready`=1, no `op_ack` → exactly 2 operations accepted, `op_valid`=0, `outstanding`=2. One ack → one more issue.
- `start_flush` at cycle 3 of the reset sweep → reset sweep completes, `sweep_done` pulses, then FL_SWEEP issues sets 0..7 with `op_is_flush`=1.
- `rst_state` during FL_SWEEP at set 5 with 2 in flight → next cycle RST_SWEEP at `op_set`=0, `flush_stall`=0, `rst_stall`=1. RST_DRAIN waits for all acks.
- Simultaneous accept and `op_ack` with `outstanding`=1 → stays 1. `op_ack` in IDLE with count 0 → stays 0.
- Build without `LLC_FLUSH_SEQ_EN`, pulse `start_flush` in IDLE → no `op_valid`, `flush_stall` stays 0.

Source files
------------

// File: rtl/llc_rst_flush_seq.sv
// LLC reset/flush set sequencer: walks every set once per sweep.
// Flush sweeps exist only when LLC_FLUSH_SEQ_EN is defined.
module llc_rst_flush_seq #(
    parameter int  SET_BITS = 8,
    parameter int  MAX_OUT  = 4,
    localparam int CW       = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_state,
    input  logic                start_flush,
    input  logic                op_ready,
    input  logic                op_ack,
    output logic                op_valid,
    output logic [SET_BITS-1:0] op_set,
    output logic                op_is_flush,
    output logic                rst_stall,
    output logic                flush_stall,
    output logic                sweep_done,
    output logic [CW-1:0]       outstanding
);

    localparam logic [CW-1:0]       MAX_C = CW'(MAX_OUT);
    localparam logic [SET_BITS-1:0] LAST  = '1;

    typedef enum logic [2:0] {
        INIT,
        RST_SWEEP,
        RST_DRAIN,
        IDLE
`ifdef LLC_FLUSH_SEQ_EN
        ,
        FL_SWEEP,
        FL_DRAIN
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] set_q, set_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                sweeping;
    logic                accept;
    logic                dec;

`ifdef LLC_FLUSH_SEQ_EN
    logic pend_q, pend_d;
    logic in_rst;
    assign sweeping    = (state_q == RST_SWEEP) ||
                         (state_q == FL_SWEEP);
    assign in_rst      = (state_q == INIT) ||
                         (state_q == RST_SWEEP) ||
                         (state_q == RST_DRAIN);
    assign op_is_flush = (state_q == FL_SWEEP);
    assign flush_stall = (state_q == FL_SWEEP) ||
                         (state_q == FL_DRAIN);
`else
    logic unused_start_flush;
    assign unused_start_flush = start_flush;
    assign sweeping    = (state_q == RST_SWEEP);
    assign op_is_flush = 1'b0;
    assign flush_stall = 1'b0;
`endif

    assign op_valid    = sweeping && (cnt_q < MAX_C);
    assign op_set      = set_q;
    assign rst_stall   = (state_q == INIT) ||
                         (state_q == RST_SWEEP) ||
                         (state_q == RST_DRAIN);
    assign sweep_done  = done_q;
    assign outstanding = cnt_q;

    // A restart withdraws the offered operation, so it is never counted.
    assign accept = op_valid && op_ready && !rst_state;
    assign dec    = op_ack && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !dec) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && dec) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Drain exits on the post-update count so the last ack ends it.
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        done_d  = 1'b0;
`ifdef LLC_FLUSH_SEQ_EN
        pend_d  = pend_q;
        if (start_flush && in_rst) begin
            pend_d = 1'b1;
        end
`endif
        if (accept) begin
            set_d = set_q + SET_BITS'(1);
        end
        unique case (state_q)
            INIT: begin
                state_d = RST_SWEEP;
                set_d   = '0;
            end
            RST_SWEEP: begin
                if (accept && set_q == LAST) begin
                    state_d = RST_DRAIN;
                end
            end
            RST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            IDLE: begin
`ifdef LLC_FLUSH_SEQ_EN
                if (start_flush || pend_q) begin
                    state_d = FL_SWEEP;
                    set_d   = '0;
                    pend_d  = 1'b0;
                end
`endif
            end
`ifdef LLC_FLUSH_SEQ_EN
            FL_SWEEP: begin
                if (accept && set_q == LAST) begin
                    state_d = FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = INIT;
            end
        endcase
        if (rst_state) begin
            state_d = RST_SWEEP;
            set_d   = '0;
            done_d  = 1'b0;
`ifdef LLC_FLUSH_SEQ_EN
            pend_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            set_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef LLC_FLUSH_SEQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

endmodule
